alu_exec_unit: RTL and testbench

- Execute-stage consumer of the ALU control code produced by the ALU control decode in the ID/EX path.
- Takes the control code plus two operands with a valid/ready handshake and produces a registered 32-bit result.
- Single-cycle ops complete in 1 cycle. MUL uses an iterative shift-add engine and holds the pipeline through stall_o.

---
 rtl/alu_exec_unit_pkg.sv | 32 +++
 rtl/alu_exec_unit_mul_iter.sv | 87 ++++++++
 rtl/alu_exec_unit.sv | 110 +++++++++++
 tb/tb_alu_exec_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control-code definitions and widths used by the execute-stage ALU.
// The macro block mirrors the ID-stage control decode so both sides agree on encodings.
`ifndef ALU_DEFINE_V
`define ALU_DEFINE_V
`define CRTL_LEN 3
`define AND  3'b000
`define XOR  3'b001
`define SLL  3'b010
`define ADD  3'b011
`define SUB  3'b100
`define MUL  3'b101
`define SRAI 3'b110
`define DATA_LEN 32
`endif

package alu_exec_unit_pkg;
   localparam int DATA_LEN = `DATA_LEN;

   typedef enum logic [`CRTL_LEN-1:0] {
      OP_AND  = `AND,
      OP_XOR  = `XOR,
      OP_SLL  = `SLL,
      OP_ADD  = `ADD,
      OP_SUB  = `SUB,
      OP_MUL  = `MUL,
      OP_SRAI = `SRAI
   } alu_op_e;

   function automatic logic is_mul(input logic [`CRTL_LEN-1:0] code);
      return code == `MUL;
   endfunction
endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// mul_iter: iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// Optional MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module mul_iter #(
   parameter int DATA_W   = 32,
   parameter int MUL_STEP = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              active_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] multiplicand_i,
   input  logic [DATA_W-1:0] multiplier_i,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o
);
   localparam int STEPS = DATA_W / MUL_STEP;
   localparam int CNT_W = $clog2(STEPS + 1);

   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] pp [MUL_STEP];
   logic [DATA_W-1:0] partial_sum;
   logic [DATA_W-1:0] mplier_shift;
   logic              last_step;

   generate
      for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
         assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
      end
   endgenerate

   always_comb begin
      partial_sum = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         partial_sum = partial_sum + pp[i];
      end
   end

   assign mplier_shift = mplier_q >> MUL_STEP;

`ifdef MUL_EARLY_TERM_EN
   // Remaining multiplier bits all zero means the accumulator is already final.
   assign last_step = (count_q == CNT_W'(1)) || (mplier_shift == '0);
`else
   assign last_step = (count_q == CNT_W'(1));
`endif

   assign done_o   = active_i && !flush_i && last_step;
   assign result_o = acc_q + partial_sum;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (start_i) begin
         mcand_d  = multiplicand_i;
         mplier_d = multiplier_i;
         acc_d    = '0;
         count_d  = CNT_W'(STEPS);
      end else if (active_i) begin
         acc_d    = acc_q + partial_sum;
         mcand_d  = mcand_q << MUL_STEP;
         mplier_d = mplier_shift;
         count_d  = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with 1-cycle ops and an iterative MUL that stalls the pipe.
// Optional macro MUL_EARLY_TERM_EN (in mul_iter) enables early MUL termination.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W   = DATA_LEN,
   parameter int MUL_STEP = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic [`CRTL_LEN-1:0] ALUCtrl_i,
   input  logic [DATA_W-1:0]    data1_i,
   input  logic [DATA_W-1:0]    data2_i,
   input  logic                 flush_i,
   output logic                 ready_o,
   output logic                 valid_o,
   output logic [DATA_W-1:0]    data_o,
   output logic                 stall_o
);
   localparam int SH_W = $clog2(DATA_W);

   typedef enum logic {IDLE, MUL_BUSY} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              mul_start, mul_done;
   logic [DATA_W-1:0] mul_result;
   logic [DATA_W-1:0] alu_result;
   logic [SH_W-1:0]   shamt;

   assign shamt = data2_i[SH_W-1:0];

   always_comb begin
      alu_result = '0;
      case (ALUCtrl_i)
         `AND:    alu_result = data1_i & data2_i;
         `XOR:    alu_result = data1_i ^ data2_i;
         `SLL:    alu_result = data1_i << shamt;
         `ADD:    alu_result = data1_i + data2_i;
         `SUB:    alu_result = data1_i - data2_i;
         `SRAI:   alu_result = DATA_W'($signed(data1_i) >>> shamt);
         default: alu_result = '0;
      endcase
   end

   mul_iter #(
      .DATA_W   (DATA_W),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (mul_start),
      .active_i       (state_q == MUL_BUSY),
      .flush_i        (flush_i),
      .multiplicand_i (data1_i),
      .multiplier_i   (data2_i),
      .done_o         (mul_done),
      .result_o       (mul_result)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         IDLE: begin
            // A flush in the accept cycle cancels the op before it touches any state.
            if (valid_i && !flush_i) begin
               if (is_mul(ALUCtrl_i)) begin
                  mul_start = 1'b1;
                  state_d   = MUL_BUSY;
               end else begin
                  data_d  = alu_result;
                  valid_d = 1'b1;
               end
            end
         end
         MUL_BUSY: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (mul_done) begin
               data_d  = mul_result;
               valid_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign ready_o = (state_q == IDLE);
   assign stall_o = (state_q == MUL_BUSY);
   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results are queued at issue and
// matched (value and cycle) whenever the DUT pulses valid_o.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   logic                 clk_i;
   logic                 rst_i;
   logic                 valid_i;
   logic [`CRTL_LEN-1:0] ctrl;
   logic [31:0]          data1_i;
   logic [31:0]          data2_i;
   logic                 flush_i;
   logic                 ready_o;
   logic                 valid_o;
   logic [31:0]          data_o;
   logic                 stall_o;

`ifdef MUL_EARLY_TERM_EN
   localparam int ET = 1;
`else
   localparam int ET = 0;
`endif

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   alu_exec_unit #(.DATA_W(32), .MUL_STEP(1)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ALUCtrl_i (ctrl),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .flush_i   (flush_i),
      .ready_o   (ready_o),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .stall_o   (stall_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   // Issue one op for one cycle; extra = cycles after the accept edge until valid_o.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int extra);
      valid_i = 1'b1;
      ctrl    = op;
      data1_i = a;
      data2_i = b;
      sb.push_back('{expv, cyc + 1 + extra});
      $display("issue op=%0d a=%h b=%h exp=%h due=%0d", op, a, b, expv, cyc + 1 + extra);
      step();
      valid_i = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready_o !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk("ready_timeout", {31'b0, ready_o}, 32'd1);
   endtask

   always @(negedge clk_i) begin
      if (valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL stray_valid observed=data %h expected=no valid_o cycle=%0d", data_o, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("result data=%h exp=%h cycle=%0d due=%0d", data_o, e.data, cyc, e.due);
            chk("result", data_o, e.data);
            chk("latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      rst_i   = 1'b1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      ctrl    = `AND;
      data1_i = '0;
      data2_i = '0;
      step();
      step();
      chk("rst_ready", {31'b0, ready_o}, 32'd1);
      chk("rst_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      rst_i = 1'b0;
      step();

      // Back-to-back single-cycle ops.
      send(`ADD,  32'hFFFF_FFFF, 32'd1,  32'h0000_0000, 0);
      send(`SUB,  32'd5,         32'd7,  32'hFFFF_FFFE, 0);
      send(`SRAI, 32'h8000_0000, 32'd4,  32'hF800_0000, 0);
      send(`SLL,  32'd1,         32'd31, 32'h8000_0000, 0);
      send(`AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
      send(`XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
      send(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 0);
      step();

      // MUL 7*(-3) with a different op held on valid_i through the busy period.
      valid_i = 1'b1;
      ctrl    = `MUL;
      data1_i = 32'd7;
      data2_i = 32'hFFFF_FFFD;
      sb.push_back('{32'hFFFF_FFEB, cyc + 1 + 32});
      sb.push_back('{32'd30, cyc + 1 + 33});
      $display("issue MUL 7*fffffffd due=%0d with ADD 10+20 held", cyc + 33);
      step();
      ctrl    = `ADD;
      data1_i = 32'd10;
      data2_i = 32'd20;
      for (int k = 0; k < 32; k++) begin
         chk("mul_stall", {31'b0, stall_o}, 32'd1);
         chk("mul_ready", {31'b0, ready_o}, 32'd0);
         step();
      end
      chk("mul_ready_back", {31'b0, ready_o}, 32'd1);
      step();
      valid_i = 1'b0;
      step();

      // Flush in IDLE cancels an op accepted the same cycle.
      valid_i = 1'b1;
      flush_i = 1'b1;
      ctrl    = `ADD;
      data1_i = 32'd1;
      data2_i = 32'd1;
      step();
      valid_i = 1'b0;
      flush_i = 1'b0;
      step();
      chk("idle_flush_data", data_o, 32'd30);

      // Flush at busy cycle 10 of a MUL.
      valid_i = 1'b1;
      ctrl    = `MUL;
      data1_i = 32'd5;
      data2_i = 32'h8000_0001;
      step();
      valid_i = 1'b0;
      for (int k = 0; k < 9; k++) step();
      chk("pre_flush_stall", {31'b0, stall_o}, 32'd1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flush_ready", {31'b0, ready_o}, 32'd1);
      chk("flush_stall", {31'b0, stall_o}, 32'd0);
      chk("flush_data", data_o, 32'd30);
      send(`ADD, 32'd2, 32'd3, 32'd5, 0);
      step();

      // Operand-dependent latency only with early termination.
      send(`MUL, 32'h0000_1234, 32'd3, 32'h0000_369C, (ET != 0) ? 2 : 32);
      wait_ready();
      step();
      send(`MUL, 32'h0000_0063, 32'd0, 32'h0000_0000, (ET != 0) ? 1 : 32);
      wait_ready();
      step();

      // Reset in the middle of a MUL: abandoned, no result.
      valid_i = 1'b1;
      ctrl    = `MUL;
      data1_i = 32'd3;
      data2_i = 32'h8000_0000;
      step();
      valid_i = 1'b0;
      for (int k = 0; k < 5; k++) step();
      rst_i = 1'b1;
      step();
      step();
      chk("midrst_ready", {31'b0, ready_o}, 32'd1);
      chk("midrst_valid", {31'b0, valid_o}, 32'd0);
      chk("midrst_stall", {31'b0, stall_o}, 32'd0);
      chk("midrst_data", data_o, 32'd0);
      rst_i = 1'b0;
      for (int k = 0; k < 40; k++) step();

      begin
         int n = 0;
         while (sb.size() != 0 && n < 100) begin
            step();
            n++;
         end
      end
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
